// File: rtl/irt_tracker_retire.sv
// irt_tracker_retire
// Register dependency table for the issue buffer. Each architectural register
// has a row of BS column bits in two tables: RS (column reads the register)
// and RD (column writes the register). Inserting an instruction into a column
// produces a registered dependency vector against the other live columns;
// retiring a column frees it and clears its bits from every row.
module irt_tracker_retire #(
    parameter  int REGNUM   = 32,
    parameter  int BS       = 16,
    parameter  int NSRC     = 2,
    parameter  int ZERO_REG = 1,
    localparam int RW       = $clog2(REGNUM),
    localparam int IW       = $clog2(BS),
    localparam int OW       = $clog2(BS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ins_valid,
    output logic               ins_ready,
    input  logic               ins_null,
    input  logic [NSRC*RW-1:0] ins_rs,
    input  logic [RW-1:0]      ins_rd,
    input  logic [IW-1:0]      ins_idx,
    input  logic               ret_valid,
    input  logic [IW-1:0]      ret_idx,
    output logic               dep_valid,
    output logic [IW-1:0]      dep_idx,
    output logic [BS-1:0]      dep_vec,
    output logic [OW-1:0]      occupancy
);

    // Table state
    logic [BS-1:0] rs_q [REGNUM];
    logic [BS-1:0] rs_d [REGNUM];
    logic [BS-1:0] rd_q [REGNUM];
    logic [BS-1:0] rd_d [REGNUM];
    logic [BS-1:0] occ_q, occ_d;

    // Output / bookkeeping state
    logic          dep_valid_q, dep_valid_d;
    logic [IW-1:0] dep_idx_q,   dep_idx_d;
    logic [BS-1:0] dep_vec_q,   dep_vec_d;
    logic [OW-1:0] occ_cnt_q,   occ_cnt_d;

    // Combinational helpers
    logic          accept;
    logic          ret_eff;
    logic [BS-1:0] ins_oh;
    logic [BS-1:0] ret_oh;
    logic [BS-1:0] live;
    logic [BS-1:0] hit;
    logic [BS-1:0] vec;
    logic [BS-1:0] clr;

    // A register takes part in tracking unless it is the hardwired zero
    // register, or lies outside the table when REGNUM is not a power of two.
    function automatic logic reg_used(input logic [RW-1:0] r);
        logic ok;
        ok = (int'(r) < REGNUM);
        if ((ZERO_REG != 0) && (r == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Handshake, retire qualification and dependency vector from pre-edge state
    always_comb begin
        ins_oh    = BS'(1) << ins_idx;
        ret_oh    = ret_valid ? (BS'(1) << ret_idx) : '0;
        ins_ready = ~occ_q[ins_idx] | (ret_valid & (ret_idx == ins_idx));
        accept    = ins_valid & ins_ready;
        ret_eff   = ret_valid & occ_q[ret_idx];
        live      = occ_q & ~ins_oh & ~ret_oh;

        hit = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (reg_used(ins_rs[k*RW +: RW])) begin
                hit = hit | rd_q[ins_rs[k*RW +: RW]];
            end
        end
        if (reg_used(ins_rd)) begin
            hit = hit | rs_q[ins_rd] | rd_q[ins_rd];
        end

        vec = ins_null ? '1 : (hit & live);
    end

    // Next-state: retire clears first, then an accepted insert reclaims the
    // column, so a same-column retire+insert leaves the column occupied.
    always_comb begin
        rs_d  = rs_q;
        rd_d  = rd_q;
        clr   = (ret_eff ? ret_oh : '0) | (accept ? ins_oh : '0);
        occ_d = occ_q & ~clr;

        for (int unsigned r = 0; r < REGNUM; r++) begin
            rs_d[r] = rs_q[r] & ~clr;
            rd_d[r] = rd_q[r] & ~clr;
        end

        if (accept) begin
            occ_d = occ_d | ins_oh;
            if (!ins_null) begin
                for (int unsigned k = 0; k < NSRC; k++) begin
                    if (reg_used(ins_rs[k*RW +: RW])) begin
                        rs_d[ins_rs[k*RW +: RW]] = rs_d[ins_rs[k*RW +: RW]] | ins_oh;
                    end
                end
                if (reg_used(ins_rd)) begin
                    rd_d[ins_rd] = rd_d[ins_rd] | ins_oh;
                end
            end
        end

        unique case ({accept, ret_eff})
            2'b10:   occ_cnt_d = occ_cnt_q + OW'(1);
            2'b01:   occ_cnt_d = occ_cnt_q - OW'(1);
            default: occ_cnt_d = occ_cnt_q;
        endcase

        dep_valid_d = accept;
        dep_idx_d   = accept ? ins_idx : dep_idx_q;
        dep_vec_d   = accept ? vec     : dep_vec_q;
    end

    // State register with synchronous reset overriding any concurrent update
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q        <= '{default: '0};
            rd_q        <= '{default: '0};
            occ_q       <= '0;
            occ_cnt_q   <= '0;
            dep_valid_q <= 1'b0;
            dep_idx_q   <= '0;
            dep_vec_q   <= '0;
        end else begin
            rs_q        <= rs_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
            occ_cnt_q   <= occ_cnt_d;
            dep_valid_q <= dep_valid_d;
            dep_idx_q   <= dep_idx_d;
            dep_vec_q   <= dep_vec_d;
        end
    end

    assign dep_valid = dep_valid_q;
    assign dep_idx   = dep_idx_q;
    assign dep_vec   = dep_vec_q;
    assign occupancy = occ_cnt_q;

endmodule

// File: tb/tb_irt_tracker_retire.sv
// Scoreboard bench for irt_tracker_retire: stimulus pushes expected dep
// responses, a negedge monitor pops and compares whenever dep_valid is high.
module tb_irt_tracker_retire;

    localparam int REGNUM = 32;
    localparam int BS     = 16;
    localparam int NSRC   = 2;
    localparam int RW     = 5;
    localparam int IW     = 4;
    localparam int OW     = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               ins_valid;
    logic               ins_ready;
    logic               ins_null;
    logic [NSRC*RW-1:0] ins_rs;
    logic [RW-1:0]      ins_rd;
    logic [IW-1:0]      ins_idx;
    logic               ret_valid;
    logic [IW-1:0]      ret_idx;
    logic               dep_valid;
    logic [IW-1:0]      dep_idx;
    logic [BS-1:0]      dep_vec;
    logic [OW-1:0]      occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [BS-1:0] vec;
    } exp_t;
    exp_t exp_q [$];

    irt_tracker_retire #(
        .REGNUM  (REGNUM),
        .BS      (BS),
        .NSRC    (NSRC),
        .ZERO_REG(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .ins_null (ins_null),
        .ins_rs   (ins_rs),
        .ins_rd   (ins_rd),
        .ins_idx  (ins_idx),
        .ret_valid(ret_valid),
        .ret_idx  (ret_idx),
        .dep_valid(dep_valid),
        .dep_idx  (dep_idx),
        .dep_vec  (dep_vec),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Monitor: every dep_valid must match the oldest expected response
    always @(negedge clk) begin
        if (mon_en && dep_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dep_unexpected: got idx=%0d vec=%h, required no dep_valid", dep_idx, dep_vec);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (dep_idx !== e.idx || dep_vec !== e.vec) begin
                    n_fail++;
                    $display("FAIL dep_vec: got idx=%0d vec=%h, required idx=%0d vec=%h",
                             dep_idx, dep_vec, e.idx, e.vec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // One cycle of stimulus; ready is checked before the edge and an
    // expected dep response is queued when the insert will be accepted.
    task automatic cyc(input bit iv, input bit nul, input int rs0, input int rs1, input int rd,
                       input int idx, input bit rv, input int ridx,
                       input bit exp_rdy, input logic [BS-1:0] exp_vec);
        @(negedge clk);
        ins_valid = iv;
        ins_null  = nul;
        ins_rs    = {RW'(rs1), RW'(rs0)};
        ins_rd    = RW'(rd);
        ins_idx   = IW'(idx);
        ret_valid = rv;
        ret_idx   = IW'(ridx);
        #1;
        if (iv) begin
            check("ins_ready", 32'(ins_ready), 32'(exp_rdy));
            if (exp_rdy) exp_q.push_back('{idx: IW'(idx), vec: exp_vec});
        end
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        ret_valid = 1'b0;
        ins_null  = 1'b0;
    endtask

    task automatic ins(input int idx, input int rs0, input int rs1, input int rd,
                       input logic [BS-1:0] v);
        cyc(1, 0, rs0, rs1, rd, idx, 0, 0, 1, v);
    endtask

    task automatic ret(input int idx);
        cyc(0, 0, 0, 0, 0, 0, 1, idx, 0, '0);
    endtask

    task automatic occ_is(input string name, input int n);
        @(negedge clk);
        check(name, 32'(occupancy), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ins_valid = 1'b0; ins_null = 1'b0; ins_rs = '0; ins_rd = '0;
        ins_idx = '0; ret_valid = 1'b0; ret_idx = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        // T1 reset state
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_dep_valid", 32'(dep_valid), 0);
        for (int i = 0; i < BS; i++) begin
            ins_idx = IW'(i);
            #1;
            check("rst_ins_ready", 32'(ins_ready), 1);
        end
        mon_en = 1'b1;

        // T2 RAW
        ins(0, 0, 0, 5, 16'h0000);
        ins(1, 5, 7, 8, 16'h0001);
        occ_is("t2_occupancy", 2);

        // T3 WAR / WAW on a clean table
        ret(0);
        ret(1);
        occ_is("t3_occ_empty", 0);
        ins(0, 3, 0, 0, 16'h0000);
        ins(1, 0, 0, 3, 16'h0001);
        ins(2, 0, 0, 3, 16'h0003);

        // T4 retire col0 while inserting col3 (would be 16'h0007 without retire)
        cyc(1, 0, 3, 3, 3, 3, 1, 0, 1, 16'h0006);
        occ_is("t4_occupancy", 3);
        ret(0);  // unoccupied: no-op
        occ_is("t4_ret_unocc", 3);

        // T5 fill remaining columns with nulls
        ins_null = 1'b0;
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF);
        for (int i = 4; i < BS; i++) cyc(1, 1, 0, 0, 0, i, 0, 0, 1, 16'hFFFF);
        occ_is("t5_full", 16);
        cyc(1, 0, 3, 0, 0, 4, 0, 0, 0, '0);  // rejected
        occ_is("t5_rejected", 16);
        cyc(1, 0, 3, 0, 0, 4, 1, 4, 1, 16'h000E);
        occ_is("t5_collision", 16);

        // T6 null and zero register
        ret(5);
        occ_is("t6_ret5", 15);
        cyc(1, 1, 0, 0, 0, 5, 0, 0, 1, 16'hFFFF);
        ret(6);
        ins(6, 0, 0, 0, 16'h0000);
        occ_is("t6_occupancy", 16);

        // Retire clears table bits: only col3 still writes r3
        ret(1);
        ret(2);
        ins(1, 3, 3, 0, 16'h0008);
        occ_is("retire_clear_occ", 15);

        // Reset overrides a concurrent insert
        @(negedge clk);
        ins_valid = 1'b1; ins_null = 1'b0; ins_idx = 4'd2; ins_rs = '0; ins_rd = 5'd9; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ins_valid = 1'b0;
        @(negedge clk);
        check("rst2_dep_valid", 32'(dep_valid), 0);
        check("rst2_occupancy", 32'(occupancy), 0);
        ins(7, 3, 0, 0, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
